seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//   Run-time programmable serial pattern detector. Successor to the fixed "1101" Mealy detector.
//   Pattern length is set by MAX_LEN. Pattern and overlap mode are loadable at run time.
//   Adds input qualification and a match counter. Sits on a serial bit stream, one bit per valid clock.
//   Emits a combinational (Mealy) 1-cycle pulse on the bit that completes the pattern.
// PARAMETERS
//   MAX_LEN  8   max pattern length in bits (2..32)
//   CNT_W    8   width of match counter
//   LEN_W    $clog2(MAX_LEN+1)   derived width of length fields; do not override
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   din        in   1        serial data bit
//   din_valid  in   1        din qualifier; bit consumed only when 1
//   cfg_load   in   1        latch pat_in/len_in/ovl_in into config regs this cycle
//   pat_in     in   MAX_LEN  pattern, right-aligned; bit [len-1] is the earliest bit received
//   len_in     in   LEN_W    pattern length; 0 = detector disabled
//   ovl_in     in   1        1 = overlapping matches, 0 = non-overlapping
//   y          out  1        match pulse (Mealy, combinational from din/din_valid/state)
//   match_cnt  out  CNT_W    saturating count of matches (SEQ_DET_CNT_EN only)
// BEHAVIOUR
//   - Reset (async, immediate):
//     - history = 0, fill = 0, match_cnt = 0.
//     - Config = pattern 4'b1101, len 4, ovl 1 (default behaves as the predecessor).
//     - y = 0 while rst is high.
//   - State:
//     - hist[MAX_LEN-1:0]: last received bits, newest in bit 0.
//     - fill[LEN_W-1:0]: number of valid history bits, saturates at MAX_LEN.
//   - Candidate per cycle: cand = {hist[MAX_LEN-2:0], din}.
//   - y = din_valid & ~cfg_load & (len != 0) & (fill + 1 >= len) & (cand[len-1:0] == pat[len-1:0]).
//   - On a clock with din_valid=1 and cfg_load=0:
//     - hist <= cand.
//     - fill <= min(fill+1, MAX_LEN).
//     - If y=1 and ovl=0: fill <= 0, so matches never share bits.
//   - din_valid=0: hist and fill hold; y=0; no count.
//   - cfg_load=1:
//     - Config regs take the *_in values.
//     - hist and fill clear; the din bit is discarded; y=0 that cycle.
//     - cfg_load wins over din_valid.
//   - len_in > MAX_LEN is clamped to MAX_LEN at load.
//   - len=1: every valid bit equal to pat[0] matches.
//   - Latency: zero. y asserts in the same cycle as the final pattern bit, before the clock edge.
//   - Pattern bits above len are ignored.
// CONFIGURATION
//   SEQ_DET_CNT_EN defined:
//     - match_cnt increments on each clock edge where y=1.
//     - match_cnt saturates at all-ones and is never wrapped.
//     - match_cnt clears on rst or cfg_load.
//   SEQ_DET_CNT_EN undefined:
//     - match_cnt is tied to 0.
//     - No counter flops are synthesised.
// STRUCTURE
//   Package seq_det_pkg:
//     - DEF_PAT = 'b1101, DEF_LEN = 4, DEF_OVL = 1'b1.
//     - typedef seq_cfg_t {pat, len, ovl}.
//   Sub-module seq_det_hist:
//     - History shift register plus fill counter.
//     - Inputs: shift enable, clear, din.
//     - Outputs: hist, fill.
//   Top level holds config regs, compare/mask logic, Mealy output and optional counter.
// TESTING
//   1. Reset defaults, overlap mode:
//      - Stream 1,1,0,1,1,0,1 -> y=1 on bits 4 and 7.
//      - match_cnt=2 with SEQ_DET_CNT_EN.
//   2. Non-overlap mode:
//      - Load pat=3'b101, len=3, ovl=0. Stream 1,0,1,0,1 -> y=1 on bit 3 only.
//      - Same stream with ovl=1 -> y=1 on bits 3 and 5.
//   3. Qualifier gaps:
//      - Stream 1,1,0,1 with din_valid=0 cycles between bits -> single y at the final valid bit.
//      - y=0 on every invalid cycle.
//   4. Load collision and length limits:
//      - cfg_load asserted with din_valid=1 on the completing bit -> y=0, history cleared.
//      - len_in=0 -> y never asserts.
//      - len_in=MAX_LEN+3 -> behaves as len=MAX_LEN.
//   5. Async reset mid-pattern:
//      - After 1,1,0, pulse rst between clock edges; then send 1 -> y=0.
//      - Config returns to 1101; match_cnt=0.
//   6. Counter saturation (SEQ_DET_CNT_EN, CNT_W=2):
//      - 5 matches -> match_cnt reads 3 and holds.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
// Config storage is sized for the largest supported pattern (32 bits).
package seq_det_pkg;
  localparam int PAT_W_MAX = 32;
  localparam int LEN_W_MAX = 6;

  localparam logic [PAT_W_MAX-1:0] DEF_PAT = 'b1101;
  localparam logic [LEN_W_MAX-1:0] DEF_LEN = 4;
  localparam logic                 DEF_OVL = 1'b1;

  typedef struct packed {
    logic [PAT_W_MAX-1:0] pat;
    logic [LEN_W_MAX-1:0] len;
    logic                 ovl;
  } seq_cfg_t;
endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register (newest bit in [0]) with a saturating count
// of how many history bits are meaningful since the last clear.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift,
  input  logic               i_clr,
  input  logic               i_fill_clr,
  input  logic               i_din,
  output logic [MAX_LEN-1:0] o_hist,
  output logic [LEN_W-1:0]   o_fill
);
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[MAX_LEN-2:0], i_din};
      // A non-overlapping match forgets its bits but the raw history still shifts.
      if (i_fill_clr)
        r_fill <= '0;
      else if (r_fill != LEN_W'(MAX_LEN))
        r_fill <= r_fill + LEN_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;
endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial pattern detector with a Mealy match pulse.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ovl_in,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt
);
  localparam int FW = LEN_W_MAX + 1;
  localparam logic [LEN_W_MAX-1:0] RST_LEN =
    (int'(DEF_LEN) > MAX_LEN) ? LEN_W_MAX'(MAX_LEN) : DEF_LEN;

  seq_cfg_t               r_cfg;
  logic [MAX_LEN-1:0]     w_hist;
  logic [LEN_W-1:0]       w_fill;
  logic [LEN_W_MAX-1:0]   w_len_clamp;
  logic [PAT_W_MAX:0]     w_cand_x;
  logic [PAT_W_MAX:0]     w_mask;
  logic [FW-1:0]          w_fill_x;
  logic                   w_fill_ok;
  logic                   w_pat_ok;
  logic                   w_shift;
  logic                   w_y;

  assign w_len_clamp = (int'(len_in) > MAX_LEN) ? LEN_W_MAX'(MAX_LEN) : LEN_W_MAX'(len_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cfg <= '{pat: DEF_PAT, len: RST_LEN, ovl: DEF_OVL};
    else if (cfg_load)
      r_cfg <= '{pat: PAT_W_MAX'(pat_in), len: w_len_clamp, ovl: ovl_in};
  end

  // Compare in the full config width; the length mask discards everything above len.
  assign w_cand_x = (PAT_W_MAX+1)'({w_hist, din});

  always_comb begin
    w_mask = '0;
    for (int i = 0; i <= PAT_W_MAX; i++)
      w_mask[i] = (i < int'(r_cfg.len));
  end

  assign w_pat_ok  = ((w_cand_x ^ {1'b0, r_cfg.pat}) & w_mask) == '0;
  assign w_fill_x  = FW'(w_fill) + FW'(1);
  assign w_fill_ok = w_fill_x >= FW'(r_cfg.len);
  assign w_shift   = din_valid & ~cfg_load;
  assign w_y       = ~rst & w_shift & (r_cfg.len != '0) & w_fill_ok & w_pat_ok;
  assign y         = w_y;

  seq_det_hist #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
    .clk        (clk),
    .rst        (rst),
    .i_shift    (w_shift),
    .i_clr      (cfg_load),
    .i_fill_clr (w_y & ~r_cfg.ovl),
    .i_din      (din),
    .o_hist     (w_hist),
    .o_fill     (w_fill)
  );

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (cfg_load)
      r_cnt <= '0;
    else if (w_y && !(&r_cnt))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed vector table, hand corner sequences and
// random traffic against a bit-queue reference model.
module tb_seq_detect_prog;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               din, din_valid, cfg_load, ovl_in;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: every valid bit since the last load, plus the index where
  // the usable window starts (moved past a non-overlapping match).
  bit          q[$];
  int          start;
  logic [31:0] m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .cfg_load  (cfg_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .ovl_in    (ovl_in),
    .y         (y),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    start = 0;
    m_pat = 32'b1101;
    m_len = 4;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  function automatic bit model_y(input bit d, input bit v, input bit l);
    int n;
    bit b;
    if (!v || l || m_len == 0) return 1'b0;
    n = q.size() - start + 1;
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? d : q[q.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit d, input bit v, input bit l, input logic [7:0] p,
                      input logic [3:0] ln, input bit o, output bit yo);
    bit e;
    din = d; din_valid = v; cfg_load = l; pat_in = p; len_in = ln; ovl_in = o;
    @(negedge clk);
    e  = model_y(d, v, l);
    yo = y;
    chk("y_model", y, e);
    if (l) begin
      q.delete();
      start = 0;
      m_pat = 32'(p);
      m_len = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
      m_ovl = o;
      m_cnt = 0;
    end else if (v) begin
      q.push_back(d);
      if (e) begin
        if (!m_ovl) start = q.size();
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("match_cnt", match_cnt, CNT_EN ? m_cnt : 0);
  endtask

  task automatic send(input bit d, input bit v, output bit yo);
    step(d, v, 1'b0, '0, '0, 1'b0, yo);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] ln, input bit o);
    bit dummy;
    step(1'($urandom_range(0, 1)), 1'b1, 1'b1, p, ln, o, dummy);
  endtask

  typedef struct {
    bit         ld;
    bit         d;
    bit         v;
    logic [7:0] p;
    logic [3:0] ln;
    bit         o;
    bit         ey;
  } vec_t;

  initial begin
    vec_t tbl[$];
    bit   yo;
    bit   pat_bits[8];
    int   r;

    // Overlap defaults: 1101101
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0}); tbl.push_back('{0,1,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,0,1,8'h0,4'h0,0,0}); tbl.push_back('{0,1,1,8'h0,4'h0,0,1});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,1});
    // 101 non-overlap then overlap
    tbl.push_back('{1,0,1,8'b101,4'd3,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,1}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0});
    tbl.push_back('{1,0,1,8'b101,4'd3,1,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,1}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,1});
    // 1101 with din_valid gaps (garbage din on invalid cycles)
    tbl.push_back('{1,0,1,8'b1101,4'd4,1,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,0}); tbl.push_back('{0,1,0,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,0,8'h0,4'h0,0,0}); tbl.push_back('{0,1,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,0,8'h0,4'h0,0,0}); tbl.push_back('{0,0,1,8'h0,4'h0,0,0});
    tbl.push_back('{0,0,0,8'h0,4'h0,0,0}); tbl.push_back('{0,1,0,8'h0,4'h0,0,0});
    tbl.push_back('{0,1,1,8'h0,4'h0,0,1}); tbl.push_back('{0,1,0,8'h0,4'h0,0,0});

    rst = 1'b1; din = 0; din_valid = 0; cfg_load = 0; pat_in = '0; len_in = '0; ovl_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    din = 1'b1; din_valid = 1'b1;
    #1;
    chk("rst_y", y, 0);
    chk("rst_cnt", match_cnt, 0);
    din = 1'b0; din_valid = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, tbl[i].ld, tbl[i].p, tbl[i].ln, tbl[i].o, yo);
      chk($sformatf("tbl_y[%0d]", i), yo, tbl[i].ey);
    end

    // Load collides with the completing bit
    load(8'b1101, 4'd4, 1'b1);
    send(1, 1, yo); send(1, 1, yo); send(0, 1, yo);
    step(1'b1, 1'b1, 1'b1, 8'b1101, 4'd4, 1'b1, yo);
    chk("collide_y", yo, 0);
    send(1, 1, yo);
    chk("post_collide_y", yo, 0);
    send(1, 1, yo); send(0, 1, yo); send(1, 1, yo);
    chk("refill_y", yo, 1);

    // Length zero disables detection
    load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send(1'b1, 1'b1, yo);
      chk("len0_y", yo, 0);
    end

    // Oversized length clamps to MAX_LEN
    load(8'b10110011, 4'(MAX_LEN + 3), 1'b1);
    for (int i = 0; i < 8; i++) pat_bits[i] = 1'((8'b10110011 >> (7 - i)) & 8'd1);
    for (int i = 0; i < 8; i++) begin
      send(pat_bits[i], 1'b1, yo);
      if (i == 6) chk("lenclamp_early_y", yo, 0);
    end
    chk("lenclamp_y", yo, 1);

    // Async reset between edges, mid-pattern
    load(8'b1101, 4'd4, 1'b1);
    load(8'b011, 4'd3, 1'b0);
    send(1, 1, yo); send(1, 1, yo); send(0, 1, yo);
    din = 1'b1; din_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse_y", y, 0);
    chk("rst_pulse_cnt", match_cnt, 0);
    rst = 1'b0;
    model_reset();
    send(1, 1, yo);
    chk("post_rst_y", yo, 0);
    send(1, 1, yo); send(0, 1, yo); send(1, 1, yo);
    chk("post_rst_default_y", yo, 1);

    // Counter saturation: five overlapping 1101 matches
    load(8'b1101, 4'd4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) send(1, 1, yo);
      send(1, 1, yo); send(0, 1, yo); send(1, 1, yo);
      chk("sat_match_y", yo, 1);
    end
    chk("sat_cnt", match_cnt, CNT_EN ? 3 : 0);
    send(1, 1, yo); send(0, 1, yo); send(1, 1, yo);
    chk("sat_hold_cnt", match_cnt, CNT_EN ? 3 : 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4)
        load(8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11))
                                                        : 4'($urandom_range(1, 3)),
             1'($urandom_range(0, 1)));
      else
        send(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8, yo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
